// File: rtl/waveform_playback.sv
// Waveform playback: AXI-Stream prefetch FIFO feeding one I/Q sample per clock to a DAC.
// Define WF_PLAYBACK_UNDERRUN_COUNT_EN to build the saturating underrun cycle counter.
module waveform_playback #(
  parameter int FIFO_DEPTH    = 16,
  parameter int PREFILL_LEVEL = 8
) (
  input  logic        clk_in1,
  input  logic        rst,
  input  logic        wf_read_ready,
  input  logic        play_trigger,
  input  logic [15:0] play_len,
  input  logic [31:0] wfin_axis_tdata,
  input  logic        wfin_axis_tvalid,
  input  logic        wfin_axis_tlast,
  output logic        wfin_axis_tready,
  output logic [15:0] dac_out_i,
  output logic [15:0] dac_out_q,
  output logic        dac_out_valid,
  output logic        play_active,
  output logic        play_done,
  output logic        underrun,
  output logic [15:0] underrun_count
);
  // state    | meaning
  // IDLE     | waiting for a trigger while the waveform store is ready
  // PREFETCH | filling the FIFO up to PREFILL_LEVEL or the tlast word
  // PLAY     | one sample per clock to the DAC, zeros on underrun
  // FLUSH    | discarding beats until tlast is accepted
  // DONE     | single-cycle completion pulse

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PREFILL_C = (AW+1)'(PREFILL_LEVEL);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {IDLE, PREFETCH, PLAY, FLUSH, DONE} state_t;

  state_t        state;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   remaining;
  logic          last_seen;

  logic          fill_state;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          last_known;
  logic          play_end;
  logic          trig_ok;
  logic [32:0]   head;

  assign fill_state       = (state == PREFETCH) || (state == PLAY);
  assign wfin_axis_tready = (fill_state && (count != DEPTH_C)) || (state == FLUSH);
  assign push             = fill_state && wfin_axis_tvalid && wfin_axis_tready;
  assign pop              = (state == PLAY) && (count != '0);
  assign head             = mem[rd_ptr];
  assign push_last        = push && wfin_axis_tlast;
  assign last_known       = last_seen || push_last;
  assign trig_ok          = (state == IDLE) && play_trigger && wf_read_ready;
  // remaining is a down-counter of samples still owed; terminal count is 1 on the final emit
  assign play_end         = (state == PLAY) && ((remaining == 16'd1) || (pop && head[32]));

  always_ff @(posedge clk_in1) begin
    if (push) mem[wr_ptr] <= {wfin_axis_tlast, wfin_axis_tdata};
  end

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      remaining     <= '0;
      last_seen     <= 1'b0;
      dac_out_i     <= '0;
      dac_out_q     <= '0;
      dac_out_valid <= 1'b0;
      play_active   <= 1'b0;
      play_done     <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      dac_out_valid <= 1'b0;
      dac_out_i     <= '0;
      dac_out_q     <= '0;
      play_done     <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (push_last) last_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (trig_ok) begin
            remaining <= play_len;
            last_seen <= 1'b0;
            underrun  <= 1'b0;
            if (play_len == 16'd0) begin
              state <= FLUSH;
            end else begin
              state       <= PREFETCH;
              play_active <= 1'b1;
            end
          end
        end
        PREFETCH: begin
          if ((count >= PREFILL_C) || last_seen) state <= PLAY;
        end
        PLAY: begin
          dac_out_valid <= 1'b1;
          remaining     <= remaining - 16'd1;
          if (pop) begin
            dac_out_i <= head[31:16];
            dac_out_q <= head[15:0];
          end else begin
            underrun <= 1'b1;
          end
          if (play_end) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            play_active <= 1'b0;
            if (last_known) begin
              state     <= DONE;
              play_done <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (wfin_axis_tvalid && wfin_axis_tlast) begin
            state     <= DONE;
            play_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WF_PLAYBACK_UNDERRUN_COUNT_EN
  logic [15:0] urun_cnt;

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      urun_cnt <= '0;
    end else if (trig_ok) begin
      urun_cnt <= '0;
    end else if ((state == PLAY) && !pop && (urun_cnt != 16'hFFFF)) begin
      urun_cnt <= urun_cnt + 16'd1;
    end
  end

  assign underrun_count = urun_cnt;
`else
  assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_waveform_playback.sv
// Bench for waveform_playback: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed end results.
module tb_waveform_playback;
  localparam int DEPTH   = 8;
  localparam int PREFILL = 4;

  logic        clk_in1 = 1'b0;
  logic        rst = 1'b1;
  logic        wf_read_ready = 1'b0;
  logic        play_trigger = 1'b0;
  logic [15:0] play_len = '0;
  logic [31:0] wfin_axis_tdata = '0;
  logic        wfin_axis_tvalid = 1'b0;
  logic        wfin_axis_tlast = 1'b0;
  logic        wfin_axis_tready;
  logic [15:0] dac_out_i;
  logic [15:0] dac_out_q;
  logic        dac_out_valid;
  logic        play_active;
  logic        play_done;
  logic        underrun;
  logic [15:0] underrun_count;

  waveform_playback #(.FIFO_DEPTH(DEPTH), .PREFILL_LEVEL(PREFILL)) dut (
    .clk_in1(clk_in1), .rst(rst), .wf_read_ready(wf_read_ready),
    .play_trigger(play_trigger), .play_len(play_len),
    .wfin_axis_tdata(wfin_axis_tdata), .wfin_axis_tvalid(wfin_axis_tvalid),
    .wfin_axis_tlast(wfin_axis_tlast), .wfin_axis_tready(wfin_axis_tready),
    .dac_out_i(dac_out_i), .dac_out_q(dac_out_q), .dac_out_valid(dac_out_valid),
    .play_active(play_active), .play_done(play_done), .underrun(underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk_in1 = ~clk_in1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {v + 16'h1000, v};
  endfunction

  // upstream source: words 0..src_len-1, optional stall after index stall_at-1
  int src_len = 0, src_idx = 0, stall_at = -1, stall_n = 0, stall_left = 0;
  bit acc;
  initial forever begin
    @(negedge clk_in1);
    acc = wfin_axis_tvalid && wfin_axis_tready;
    @(posedge clk_in1);
    #2;
    if (acc) begin
      src_idx++;
      if (src_idx == stall_at) stall_left = stall_n;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    wfin_axis_tvalid = (src_idx < src_len) && (stall_left == 0);
    wfin_axis_tdata  = word_of(src_idx);
    wfin_axis_tlast  = (src_idx == src_len - 1);
  end

  // reference model: mode 0 idle, 1 prefetch, 2 play, 3 flush, 4 done
  int          mode = 0;
  logic [32:0] mq[$];
  int          m_len = 0, m_emitted = 0;
  bit          m_last = 0;
  logic [15:0] e_i = '0, e_q = '0;
  logic        e_valid = 0, e_active = 0, e_done = 0, e_under = 0;
  int          e_ucnt = 0;

  function automatic bit m_ready();
    return (((mode == 1) || (mode == 2)) && (mq.size() < DEPTH)) || (mode == 3);
  endfunction

  always @(posedge clk_in1) begin : model_step
    bit psh, fin;
    logic [32:0] w;
    psh = m_ready() && wfin_axis_tvalid && ((mode == 1) || (mode == 2));
    e_valid = 0; e_i = '0; e_q = '0; e_done = 0;
    if (rst) begin
      mode = 0; mq.delete(); e_active = 0; e_under = 0; e_ucnt = 0; m_last = 0;
    end else begin
      case (mode)
        0: if (play_trigger && wf_read_ready) begin
             m_len = int'(play_len); m_emitted = 0; m_last = 0; e_under = 0; e_ucnt = 0;
             mode = (play_len == 0) ? 3 : 1;
             e_active = (play_len != 0);
           end
        1: begin
             if ((mq.size() >= PREFILL) || m_last) mode = 2;
             if (psh) begin
               mq.push_back({wfin_axis_tlast, wfin_axis_tdata});
               if (wfin_axis_tlast) m_last = 1;
             end
           end
        2: begin
             fin = 0;
             e_valid = 1;
             if (mq.size() > 0) begin
               w = mq.pop_front();
               e_i = w[31:16]; e_q = w[15:0]; fin = w[32];
             end else begin
               e_under = 1;
               if (e_ucnt < 65535) e_ucnt++;
             end
             m_emitted++;
             if (m_emitted == m_len) fin = 1;
             if (psh) begin
               mq.push_back({wfin_axis_tlast, wfin_axis_tdata});
               if (wfin_axis_tlast) m_last = 1;
             end
             if (fin) begin
               mq.delete();
               e_active = 0;
               if (m_last) begin mode = 4; e_done = 1; end
               else mode = 3;
             end
           end
        3: if (wfin_axis_tvalid && wfin_axis_tlast) begin mode = 4; e_done = 1; end
        default: mode = 0;
      endcase
    end
  end

  logic [31:0] smp [256];
  int n_valid = 0, n_done = 0;

  always @(negedge clk_in1) begin
    chk("dac_out_valid", 32'(dac_out_valid), 32'(e_valid));
    chk("dac_out_i", 32'(dac_out_i), 32'(e_i));
    chk("dac_out_q", 32'(dac_out_q), 32'(e_q));
    chk("tready", 32'(wfin_axis_tready), 32'(m_ready()));
    chk("play_active", 32'(play_active), 32'(e_active));
    chk("play_done", 32'(play_done), 32'(e_done));
    chk("underrun", 32'(underrun), 32'(e_under));
`ifdef WF_PLAYBACK_UNDERRUN_COUNT_EN
    chk("underrun_count", 32'(underrun_count), 32'(e_ucnt));
`else
    chk("underrun_count", 32'(underrun_count), 32'd0);
`endif
    if (dac_out_valid) begin
      if (n_valid < 256) smp[n_valid] = {dac_out_i, dac_out_q};
      n_valid++;
    end
    if (play_done) n_done++;
  end

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic start_src(input int len, input int s_at, input int s_n);
    src_len = len; src_idx = 0; stall_at = s_at; stall_n = s_n; stall_left = 0;
    n_valid = 0; n_done = 0;
  endtask

  task automatic trigger(input int len, input bit rdy);
    play_len = 16'(len);
    wf_read_ready = rdy;
    play_trigger = 1'b1;
    tick();
    play_trigger = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c = 0;
    while ((n_done == 0) && (c < budget)) begin
      tick();
      c++;
    end
    chk({nm, " done seen"}, 32'(n_done != 0), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_samples(input string nm, input int target, input int budget);
    int c = 0;
    while ((n_valid < target) && (c < budget)) begin
      tick();
      c++;
    end
    chk({nm, " samples reached"}, 32'(n_valid >= target), 32'd1);
  endtask

  function automatic int bad_plain(input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) if (smp[k] !== word_of(k)) bad++;
    return bad;
  endfunction

  initial begin : main
    int bad;
    rst = 1'b1;
    repeat (2) @(posedge clk_in1);
    @(negedge clk_in1);
    chk("reset valid", 32'(dac_out_valid), 32'd0);
    chk("reset tready", 32'(wfin_axis_tready), 32'd0);
    chk("reset active", 32'(play_active), 32'd0);
    chk("reset done", 32'(play_done), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    chk("reset i", 32'(dac_out_i), 32'd0);

    // full 128-word playback, trigger on first cycle out of reset
    tick();
    start_src(128, -1, 0);
    rst = 1'b0;
    trigger(128, 1'b1);
    wait_done("s1", 400);
    chk("s1 sample count", n_valid, 128);
    chk("s1 data errors", bad_plain(128), 0);
    chk("s1 underrun", 32'(underrun), 32'd0);
    chk("s1 done pulses", n_done, 1);

    // short play_len, remainder flushed
    start_src(128, -1, 0);
    trigger(64, 1'b1);
    wait_done("s2", 400);
    chk("s2 sample count", n_valid, 64);
    chk("s2 data errors", bad_plain(64), 0);
    chk("s2 words consumed", src_idx, 128);
    chk("s2 done pulses", n_done, 1);

    // 5-cycle stall after word 20: FIFO holds 5 words, so exactly one zero sample
    start_src(128, 21, 5);
    trigger(128, 1'b1);
    wait_done("s3", 400);
    chk("s3 sample count", n_valid, 128);
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (k < 21) begin
        if (smp[k] !== word_of(k)) bad++;
      end else if (k == 21) begin
        if (smp[k] !== 32'd0) bad++;
      end else if (smp[k] !== word_of(k - 1)) bad++;
    end
    chk("s3 data errors", bad, 0);
    chk("s3 underrun", 32'(underrun), 32'd1);
`ifdef WF_PLAYBACK_UNDERRUN_COUNT_EN
    chk("s3 underrun_count", 32'(underrun_count), 32'd1);
`else
    chk("s3 underrun_count", 32'(underrun_count), 32'd0);
`endif

    // trigger without ready is ignored; retrigger during PLAY is ignored
    start_src(8, -1, 0);
    trigger(8, 1'b0);
    repeat (5) tick();
    chk("s4 no-ready active", 32'(play_active), 32'd0);
    chk("s4 no-ready samples", n_valid, 0);
    trigger(8, 1'b1);
    wait_samples("s4", 2, 50);
    trigger(8, 1'b1);
    wait_done("s4", 100);
    repeat (20) tick();
    chk("s4 done pulses", n_done, 1);
    chk("s4 sample count", n_valid, 8);
    chk("s4 data errors", bad_plain(8), 0);

    // reset mid-PLAY, then fresh playback
    start_src(128, -1, 0);
    trigger(128, 1'b1);
    wait_samples("s5", 30, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk_in1);
    chk("s5 post-reset valid", 32'(dac_out_valid), 32'd0);
    chk("s5 post-reset tready", 32'(wfin_axis_tready), 32'd0);
    chk("s5 post-reset active", 32'(play_active), 32'd0);
    tick();
    start_src(16, -1, 0);
    trigger(16, 1'b1);
    wait_done("s5", 100);
    chk("s5 sample count", n_valid, 16);
    chk("s5 data errors", bad_plain(16), 0);

    // play_len 0: nothing emitted, 4 words flushed
    start_src(4, -1, 0);
    trigger(0, 1'b1);
    wait_done("s6", 50);
    chk("s6 sample count", n_valid, 0);
    chk("s6 words consumed", src_idx, 4);
    chk("s6 done pulses", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
